// File: rtl/cv32e40p_apu_shared_arbiter.sv
// -----------------------------------------------------------------------------
// cv32e40p_apu_shared_arbiter
//
// Shares one APU/FPU between NUM_CORES cv32e40p cores. Core requests are
// arbitrated round-robin, and the winning request is forwarded to the FPU.
// Each issued operation pushes its source core index into an in-order tag
// FIFO. Each FPU result pops the head tag and is routed back to that core.
//
// Handshake semantics, on both the core side and the FPU side:
//   A request is offered while req is high. The payload (operands, op, flags)
//   is held stable until the cycle in which gnt is high. A transfer happens
//   exactly in a cycle with req & gnt. The requester may then drop req or
//   present a new operation in the following cycle. Results carry no
//   back-pressure: an rvalid pulse is consumed in the cycle it is seen.
//
// Ports:
//   clk_i, rst_ni         clock, synchronous active-low reset
//   core_apu_req_i/gnt_o  per-core request / grant
//   core_apu_operands_i   core-major operands, core c at [c*NARGS*32 +: NARGS*32]
//   core_apu_op_i         per-core opcode, core c at [c*WOP +: WOP]
//   core_apu_flags_i      per-core flags,  core c at [c*NDSFLAGS +: NDSFLAGS]
//   core_apu_rvalid_o     one-hot (or zero) result valid per core
//   core_apu_result_o     result, broadcast to all cores
//   core_apu_rflags_o     result flags, broadcast to all cores
//   fpu_*                 single FPU request/response port
//   outstanding_o         number of operations in flight (tag FIFO count)
//   err_o                 sticky: FPU returned a result with no tag pending
// -----------------------------------------------------------------------------
module cv32e40p_apu_shared_arbiter #(
    parameter int NUM_CORES       = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int APU_NARGS       = 3,
    parameter int APU_WOP         = 6,
    parameter int APU_NDSFLAGS    = 15,
    parameter int APU_NUSFLAGS    = 5,
    parameter int RESP_REG        = 0
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,

    input  logic [NUM_CORES-1:0]                  core_apu_req_i,
    output logic [NUM_CORES-1:0]                  core_apu_gnt_o,
    input  logic [NUM_CORES*APU_NARGS*32-1:0]     core_apu_operands_i,
    input  logic [NUM_CORES*APU_WOP-1:0]          core_apu_op_i,
    input  logic [NUM_CORES*APU_NDSFLAGS-1:0]     core_apu_flags_i,
    output logic [NUM_CORES-1:0]                  core_apu_rvalid_o,
    output logic [31:0]                           core_apu_result_o,
    output logic [APU_NUSFLAGS-1:0]               core_apu_rflags_o,

    output logic                                  fpu_req_o,
    input  logic                                  fpu_gnt_i,
    output logic [APU_NARGS*32-1:0]               fpu_operands_o,
    output logic [APU_WOP-1:0]                    fpu_op_o,
    output logic [APU_NDSFLAGS-1:0]               fpu_flags_o,
    input  logic                                  fpu_rvalid_i,
    input  logic [31:0]                           fpu_result_i,
    input  logic [APU_NUSFLAGS-1:0]               fpu_rflags_i,

    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]  outstanding_o,
    output logic                                  err_o
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int OPS_W = APU_NARGS * 32;

    // ------------------------------------------------------------------ state
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             lock_q, lock_d;
    logic [IDX_W-1:0] locked_idx_q, locked_idx_d;
    logic [IDX_W-1:0] fifo_q [MAX_OUTSTANDING];
    logic [IDX_W-1:0] fifo_d [MAX_OUTSTANDING];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;

    // -------------------------------------------------------------- datapath
    logic [IDX_W-1:0] winner;
    logic             found;
    int               cand;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic [IDX_W-1:0] head_idx;

    logic [NUM_CORES-1:0]    rsp_rvalid_d;
    logic [31:0]             rsp_result_d;
    logic [APU_NUSFLAGS-1:0] rsp_rflags_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    assign fifo_full  = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty = (count_q == '0);

    // Winner selection. A stalled request keeps the lock so the FPU sees a
    // stable payload; if the locked core withdraws its request the lock no
    // longer applies and the round-robin scan picks the next requester.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = 0;
        if (lock_q && core_apu_req_i[locked_idx_q]) begin
            winner = locked_idx_q;
            found  = 1'b1;
        end
        for (int i = 0; i < NUM_CORES; i++) begin
            cand = (int'(rr_ptr_q) + i) % NUM_CORES;
            if (!found && core_apu_req_i[cand]) begin
                winner = IDX_W'(cand);
                found  = 1'b1;
            end
        end
    end

    // No pass-through when full: a pop in the same cycle does not free a slot
    // until the next cycle, which keeps the full check purely registered.
    assign fpu_req_o = rst_ni && (|core_apu_req_i) && !fifo_full;
    assign push      = fpu_req_o && fpu_gnt_i;

    always_comb begin
        core_apu_gnt_o = '0;
        fpu_operands_o = '0;
        fpu_op_o       = '0;
        fpu_flags_o    = '0;
        if (fpu_req_o) begin
            fpu_operands_o = core_apu_operands_i[int'(winner)*OPS_W +: OPS_W];
            fpu_op_o       = core_apu_op_i[int'(winner)*APU_WOP +: APU_WOP];
            fpu_flags_o    = core_apu_flags_i[int'(winner)*APU_NDSFLAGS +: APU_NDSFLAGS];
        end
        if (push) begin
            core_apu_gnt_o[winner] = 1'b1;
        end
    end

    // Response routing: the FPU returns in issue order, so the FIFO head
    // always names the core that owns the current result.
    assign pop      = rst_ni && fpu_rvalid_i && !fifo_empty;
    assign head_idx = fifo_q[rd_ptr_q];

    always_comb begin
        rsp_rvalid_d = '0;
        rsp_result_d = '0;
        rsp_rflags_d = '0;
        if (pop) begin
            rsp_rvalid_d[head_idx] = 1'b1;
            rsp_result_d           = fpu_result_i;
            rsp_rflags_d           = fpu_rflags_i;
        end
    end

    // ------------------------------------------------------ next-state logic
    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        lock_d       = lock_q;
        locked_idx_d = locked_idx_q;
        fifo_d       = fifo_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        err_d        = err_q;

        if (push) begin
            rr_ptr_d         = (winner == IDX_W'(NUM_CORES - 1)) ? '0 : winner + 1'b1;
            lock_d           = 1'b0;
            fifo_d[wr_ptr_q] = winner;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
        end else if (fpu_req_o) begin
            lock_d       = 1'b1;
            locked_idx_d = winner;
        end

        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A result with nothing in flight means the FPU and arbiter disagree.
        if (rst_ni && fpu_rvalid_i && fifo_empty) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_ptr_q     <= '0;
            lock_q       <= 1'b0;
            locked_idx_q <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            err_q        <= 1'b0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            lock_q       <= lock_d;
            locked_idx_q <= locked_idx_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            err_q        <= err_d;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_q[i] <= fifo_d[i];
            end
        end
    end

    // --------------------------------------------------------- response path
    if (RESP_REG != 0) begin : g_resp_reg
        logic [NUM_CORES-1:0]    rsp_rvalid_q;
        logic [31:0]             rsp_result_q;
        logic [APU_NUSFLAGS-1:0] rsp_rflags_q;

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                rsp_rvalid_q <= '0;
                rsp_result_q <= '0;
                rsp_rflags_q <= '0;
            end else begin
                rsp_rvalid_q <= rsp_rvalid_d;
                rsp_result_q <= rsp_result_d;
                rsp_rflags_q <= rsp_rflags_d;
            end
        end

        assign core_apu_rvalid_o = rsp_rvalid_q;
        assign core_apu_result_o = rsp_result_q;
        assign core_apu_rflags_o = rsp_rflags_q;
    end else begin : g_resp_comb
        assign core_apu_rvalid_o = rsp_rvalid_d;
        assign core_apu_result_o = rsp_result_d;
        assign core_apu_rflags_o = rsp_rflags_d;
    end

    assign outstanding_o = count_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_cv32e40p_apu_shared_arbiter.sv
// Bench for cv32e40p_apu_shared_arbiter. Two instances: u0 has depth 4 with a
// combinational response, u1 has depth 2 with a registered response.
module tb_cv32e40p_apu_shared_arbiter;
  localparam int NC = 4;
  localparam int NA = 3;
  localparam int WOP = 6;
  localparam int NDS = 15;
  localparam int NUS = 5;

  logic clk;
  logic rst_n;

  logic [1:0][NC-1:0]        req;
  logic [1:0][NC-1:0]        gnt_o;
  logic [1:0][NC*NA*32-1:0]  operands;
  logic [1:0][NC*WOP-1:0]    op;
  logic [1:0][NC*NDS-1:0]    flags;
  logic [1:0][NC-1:0]        rvalid_o;
  logic [1:0][31:0]          result_o;
  logic [1:0][NUS-1:0]       rflags_o;
  logic [1:0]                fpu_req_o;
  logic [1:0]                fpu_gnt;
  logic [1:0][NA*32-1:0]     fpu_operands_o;
  logic [1:0][WOP-1:0]       fpu_op_o;
  logic [1:0][NDS-1:0]       fpu_flags_o;
  logic [1:0]                fpu_rvalid;
  logic [1:0][31:0]          fpu_result;
  logic [1:0][NUS-1:0]       fpu_rflags;
  logic [1:0][3:0]           outstanding;
  logic [1:0]                err_o;

  int errors = 0;
  int checks = 0;

  // ---------------------------------------------------------------- clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int MO = (g == 0) ? 4 : 2;
    localparam int CW = $clog2(MO + 1);
    logic [CW-1:0] out_w;

    cv32e40p_apu_shared_arbiter #(
      .NUM_CORES(NC), .MAX_OUTSTANDING(MO), .APU_NARGS(NA), .APU_WOP(WOP),
      .APU_NDSFLAGS(NDS), .APU_NUSFLAGS(NUS), .RESP_REG(g)
    ) u_dut (
      .clk_i(clk),
      .rst_ni(rst_n),
      .core_apu_req_i(req[g]),
      .core_apu_gnt_o(gnt_o[g]),
      .core_apu_operands_i(operands[g]),
      .core_apu_op_i(op[g]),
      .core_apu_flags_i(flags[g]),
      .core_apu_rvalid_o(rvalid_o[g]),
      .core_apu_result_o(result_o[g]),
      .core_apu_rflags_o(rflags_o[g]),
      .fpu_req_o(fpu_req_o[g]),
      .fpu_gnt_i(fpu_gnt[g]),
      .fpu_operands_o(fpu_operands_o[g]),
      .fpu_op_o(fpu_op_o[g]),
      .fpu_flags_o(fpu_flags_o[g]),
      .fpu_rvalid_i(fpu_rvalid[g]),
      .fpu_result_i(fpu_result[g]),
      .fpu_rflags_i(fpu_rflags[g]),
      .outstanding_o(out_w),
      .err_o(err_o[g])
    );
    assign outstanding[g] = 4'(out_w);
  end

  // ------------------------------------------------------------ scoreboard
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // --------------------------------------------------------------- drivers
  task automatic load_payload(input int k);
    for (int c = 0; c < NC; c++) begin
      op[k][c*WOP +: WOP] = 6'(c + 1);
      flags[k][c*NDS +: NDS] = 15'(16 + c);
      for (int a = 0; a < NA; a++)
        operands[k][(c*NA + a)*32 +: 32] = 32'hA000_0000 + 32'(c*256 + a);
    end
  endtask

  task automatic set_in(input int k, input logic [3:0] r, input logic g,
                        input logic rv, input logic [31:0] res);
    req[k] = r;
    fpu_gnt[k] = g;
    fpu_rvalid[k] = rv;
    fpu_result[k] = res;
    fpu_rflags[k] = 5'h3;
  endtask

  // Holds both instances in reset with busy inputs, checks every output is 0.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) set_in(k, 4'hF, 1'b1, 1'b1, 32'hFFFF_FFFF);
    @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_fpu_req", 128'(fpu_req_o[k]), 128'(0));
      chk("rst_gnt", 128'(gnt_o[k]), 128'(0));
      chk("rst_fpu_op", 128'(fpu_op_o[k]), 128'(0));
      chk("rst_rvalid", 128'(rvalid_o[k]), 128'(0));
      chk("rst_result", 128'(result_o[k]), 128'(0));
      chk("rst_outstanding", 128'(outstanding[k]), 128'(0));
      chk("rst_err", 128'(err_o[k]), 128'(0));
      set_in(k, 4'h0, 1'b0, 1'b0, 32'h0);
      load_payload(k);
    end
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------- vector table
  typedef struct {
    logic [3:0] req;
    logic       gnt;
    logic       rv;
    logic [3:0] e_gnt;
    logic       e_freq;
    logic [5:0] e_op;
    logic [3:0] e_rv;
    logic [3:0] e_out;
    logic       e_err;
  } vec_t;

  vec_t vecs [25];

  task automatic fill_table();
    // round-robin with all cores requesting, then push+pop at count 3
    vecs[0]  = '{4'b1111, 1, 0, 4'b0001, 1, 6'd1, 4'b0000, 4'd0, 0};
    vecs[1]  = '{4'b1111, 1, 0, 4'b0010, 1, 6'd2, 4'b0000, 4'd1, 0};
    vecs[2]  = '{4'b1111, 1, 0, 4'b0100, 1, 6'd3, 4'b0000, 4'd2, 0};
    vecs[3]  = '{4'b1111, 1, 1, 4'b1000, 1, 6'd4, 4'b0001, 4'd3, 0};
    vecs[4]  = '{4'b1111, 1, 1, 4'b0001, 1, 6'd1, 4'b0010, 4'd3, 0};
    vecs[5]  = '{4'b1111, 1, 1, 4'b0010, 1, 6'd2, 4'b0100, 4'd3, 0};
    vecs[6]  = '{4'b0000, 1, 1, 4'b0000, 0, 6'd0, 4'b1000, 4'd3, 0};
    vecs[7]  = '{4'b0000, 0, 1, 4'b0000, 0, 6'd0, 4'b0001, 4'd2, 0};
    vecs[8]  = '{4'b0000, 0, 1, 4'b0000, 0, 6'd0, 4'b0010, 4'd1, 0};
    vecs[9]  = '{4'b0000, 0, 0, 4'b0000, 0, 6'd0, 4'b0000, 4'd0, 0};
    // lock: rr=2, cores 1,3 request, FPU stalls; core 3 then withdraws
    vecs[10] = '{4'b1010, 0, 0, 4'b0000, 1, 6'd4, 4'b0000, 4'd0, 0};
    vecs[11] = '{4'b1010, 0, 0, 4'b0000, 1, 6'd4, 4'b0000, 4'd0, 0};
    vecs[12] = '{4'b1010, 0, 0, 4'b0000, 1, 6'd4, 4'b0000, 4'd0, 0};
    vecs[13] = '{4'b0010, 1, 0, 4'b0010, 1, 6'd2, 4'b0000, 4'd0, 0};
    // mirrored: core 1 withdraws, locked core 3 is granted
    vecs[14] = '{4'b1010, 0, 0, 4'b0000, 1, 6'd4, 4'b0000, 4'd1, 0};
    vecs[15] = '{4'b1010, 0, 0, 4'b0000, 1, 6'd4, 4'b0000, 4'd1, 0};
    vecs[16] = '{4'b1000, 1, 0, 4'b1000, 1, 6'd4, 4'b0000, 4'd1, 0};
    vecs[17] = '{4'b0000, 0, 1, 4'b0000, 0, 6'd0, 4'b0010, 4'd2, 0};
    vecs[18] = '{4'b0000, 0, 1, 4'b0000, 0, 6'd0, 4'b1000, 4'd1, 0};
    // push+pop at count 1, issue order 0,2,1
    vecs[19] = '{4'b0001, 1, 0, 4'b0001, 1, 6'd1, 4'b0000, 4'd0, 0};
    vecs[20] = '{4'b0100, 1, 1, 4'b0100, 1, 6'd3, 4'b0001, 4'd1, 0};
    vecs[21] = '{4'b0010, 1, 1, 4'b0010, 1, 6'd2, 4'b0100, 4'd1, 0};
    vecs[22] = '{4'b0000, 0, 1, 4'b0000, 0, 6'd0, 4'b0010, 4'd1, 0};
    // spurious rvalid at count 0
    vecs[23] = '{4'b0000, 0, 1, 4'b0000, 0, 6'd0, 4'b0000, 4'd0, 0};
    vecs[24] = '{4'b0000, 0, 0, 4'b0000, 0, 6'd0, 4'b0000, 4'd0, 1};
  endtask

  // ------------------------------------------------------ reference model
  int         m_rr;
  bit         m_lock;
  int         m_lidx;
  bit         m_err;
  int         m_q[$];
  logic [3:0]  m_rv_q;
  logic [31:0] m_res_q;
  logic [4:0]  m_flg_q;
  logic [3:0]  pend_gnt;

  task automatic model_reset();
    m_rr = 0; m_lock = 0; m_lidx = 0; m_err = 0;
    m_q.delete();
    m_rv_q = '0; m_res_q = '0; m_flg_q = '0;
    pend_gnt = '0;
  endtask

  // One cycle of the arbiter's rules, checked against instance k.
  task automatic model_cycle(input int k);
    int mo, w, c;
    bit found, full, freq, hs;
    logic [3:0]  e_gnt, crv;
    logic [31:0] cres;
    logic [4:0]  cflg;
    mo = (k == 0) ? 4 : 2;
    found = 0; w = 0;
    if (m_lock && req[k][m_lidx]) begin w = m_lidx; found = 1; end
    for (int i = 0; i < NC; i++) begin
      c = (m_rr + i) % NC;
      if (!found && req[k][c]) begin w = c; found = 1; end
    end
    full = (m_q.size() == mo);
    freq = (req[k] != 0) && !full;
    hs = freq && fpu_gnt[k];
    e_gnt = hs ? 4'(1 << w) : 4'h0;
    crv = '0; cres = '0; cflg = '0;
    if (fpu_rvalid[k] && m_q.size() > 0) begin
      crv = 4'(1 << m_q[0]);
      cres = fpu_result[k];
      cflg = fpu_rflags[k];
    end
    chk("rnd_fpu_req", 128'(fpu_req_o[k]), 128'(freq));
    chk("rnd_gnt", 128'(gnt_o[k]), 128'(e_gnt));
    chk("rnd_fpu_op", 128'(fpu_op_o[k]), freq ? 128'(op[k][w*WOP +: WOP]) : 128'(0));
    chk("rnd_fpu_operands", 128'(fpu_operands_o[k]), freq ? 128'(operands[k][w*NA*32 +: NA*32]) : 128'(0));
    chk("rnd_fpu_flags", 128'(fpu_flags_o[k]), freq ? 128'(flags[k][w*NDS +: NDS]) : 128'(0));
    chk("rnd_rvalid", 128'(rvalid_o[k]), (k == 1) ? 128'(m_rv_q) : 128'(crv));
    chk("rnd_result", 128'(result_o[k]), (k == 1) ? 128'(m_res_q) : 128'(cres));
    chk("rnd_rflags", 128'(rflags_o[k]), (k == 1) ? 128'(m_flg_q) : 128'(cflg));
    chk("rnd_outstanding", 128'(outstanding[k]), 128'(m_q.size()));
    chk("rnd_err", 128'(err_o[k]), 128'(m_err));
    if (fpu_rvalid[k]) begin
      if (m_q.size() > 0) void'(m_q.pop_front());
      else m_err = 1;
    end
    if (hs) begin
      m_q.push_back(w);
      m_rr = (w + 1) % NC;
      m_lock = 0;
    end else if (freq) begin
      m_lock = 1;
      m_lidx = w;
    end
    m_rv_q = crv; m_res_q = cres; m_flg_q = cflg;
    pend_gnt = e_gnt;
  endtask

  task automatic random_run(input int k, input int cycles);
    model_reset();
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      for (int c = 0; c < NC; c++) begin
        if (pend_gnt[c]) req[k][c] = 1'b0;
        if (!req[k][c] && $urandom_range(0, 9) < 4) begin
          req[k][c] = 1'b1;
          op[k][c*WOP +: WOP] = 6'($urandom);
          flags[k][c*NDS +: NDS] = 15'($urandom);
          for (int a = 0; a < NA; a++) operands[k][(c*NA + a)*32 +: 32] = $urandom;
        end
      end
      fpu_gnt[k] = ($urandom_range(0, 9) < 7);
      if (m_q.size() > 0) fpu_rvalid[k] = ($urandom_range(0, 1) == 1);
      else fpu_rvalid[k] = ($urandom_range(0, 49) == 0);
      fpu_result[k] = $urandom;
      fpu_rflags[k] = 5'($urandom);
      #1;
      model_cycle(k);
    end
    @(negedge clk);
    set_in(k, 4'h0, 1'b0, 1'b0, 32'h0);
  endtask

  // ------------------------------------------------------------ main test
  initial begin
    int max_out;
    logic rv_t;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      set_in(k, 4'h0, 1'b0, 1'b0, 32'h0);
      load_payload(k);
    end

    // table-driven sequence on u0
    do_reset();
    fill_table();
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      set_in(0, vecs[i].req, vecs[i].gnt, vecs[i].rv, 32'hC0DE_0000 + 32'(i));
      #1;
      chk($sformatf("vec%0d_gnt", i), 128'(gnt_o[0]), 128'(vecs[i].e_gnt));
      chk($sformatf("vec%0d_fpu_req", i), 128'(fpu_req_o[0]), 128'(vecs[i].e_freq));
      chk($sformatf("vec%0d_fpu_op", i), 128'(fpu_op_o[0]), 128'(vecs[i].e_op));
      chk($sformatf("vec%0d_rvalid", i), 128'(rvalid_o[0]), 128'(vecs[i].e_rv));
      chk($sformatf("vec%0d_result", i), 128'(result_o[0]),
          (vecs[i].e_rv != 0) ? 128'(32'hC0DE_0000 + 32'(i)) : 128'(0));
      chk($sformatf("vec%0d_outstanding", i), 128'(outstanding[0]), 128'(vecs[i].e_out));
      chk($sformatf("vec%0d_err", i), 128'(err_o[0]), 128'(vecs[i].e_err));
    end
    @(negedge clk);
    #1;
    chk("err_sticky", 128'(err_o[0]), 128'(1));
    do_reset();
    chk("err_cleared", 128'(err_o[0]), 128'(0));

    // single core back-to-back, FPU latency 3
    max_out = 0;
    for (int t = 0; t < 9; t++) begin
      @(negedge clk);
      rv_t = (t >= 3) && (t <= 7);
      set_in(0, (t < 5) ? 4'b0100 : 4'b0000, 1'b1, rv_t, rv_t ? 32'hDEAD_BEEF : 32'h0);
      #1;
      chk("b2b_gnt", 128'(gnt_o[0]), (t < 5) ? 128'(4'b0100) : 128'(0));
      chk("b2b_rvalid", 128'(rvalid_o[0]), rv_t ? 128'(4'b0100) : 128'(0));
      chk("b2b_result", 128'(result_o[0]), rv_t ? 128'(32'hDEAD_BEEF) : 128'(0));
      if (int'(outstanding[0]) > max_out) max_out = int'(outstanding[0]);
    end
    chk("b2b_max_outstanding", 128'(max_out), 128'(3));
    chk("b2b_final_outstanding", 128'(outstanding[0]), 128'(0));

    // full FIFO on u1 (depth 2) and response latency u0 vs u1
    do_reset();
    for (int t = 0; t < 7; t++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++)
        set_in(k, 4'b0001, 1'b1, (t == 4), (t == 4) ? 32'h1234_5678 : 32'h0);
      #1;
      if (t < 2) chk("full_early_gnt", 128'(gnt_o[1]), 128'(4'b0001));
      if (t == 2 || t == 3) begin
        chk("full_fpu_req", 128'(fpu_req_o[1]), 128'(0));
        chk("full_outstanding", 128'(outstanding[1]), 128'(2));
      end
      if (t == 4) begin
        chk("full_pop_no_passthru_req", 128'(fpu_req_o[1]), 128'(0));
        chk("full_pop_no_passthru_gnt", 128'(gnt_o[1]), 128'(0));
        chk("comb_rvalid_same_cycle", 128'(rvalid_o[0]), 128'(4'b0001));
        chk("reg_rvalid_not_yet", 128'(rvalid_o[1]), 128'(0));
        chk("comb_full_outstanding", 128'(outstanding[0]), 128'(4));
      end
      if (t == 5) begin
        chk("full_third_gnt", 128'(gnt_o[1]), 128'(4'b0001));
        chk("full_after_pop_outstanding", 128'(outstanding[1]), 128'(1));
        chk("reg_rvalid_next_cycle", 128'(rvalid_o[1]), 128'(4'b0001));
        chk("reg_result_next_cycle", 128'(result_o[1]), 128'(32'h1234_5678));
        chk("comb_rvalid_gone", 128'(rvalid_o[0]), 128'(0));
      end
      if (t == 6) chk("full_again_req", 128'(fpu_req_o[1]), 128'(0));
    end

    // randomized traffic against the reference model, one instance at a time
    do_reset();
    random_run(0, 600);
    do_reset();
    random_run(1, 600);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cv32e40p_apu_shared_arbiter.md
Name: cv32e40p_apu_shared_arbiter

Overview:
- Shares one APU/FPU between NUM_CORES cv32e40p cores, for a multi-core cluster wrapper; a single core keeps driving its APU port unchanged.
- Arbitrates core APU requests round-robin and forwards the winner to the FPU.
- Tags each issued operation with its source core in an in-order tag FIFO.
- Routes each FPU result back to the issuing core.

Parameters:
- NUM_CORES, 4, number of requesting cores (2..16).
- MAX_OUTSTANDING, 4, tag FIFO depth, i.e. maximum operations in flight in the FPU (1..8).
- APU_NARGS, 3, operands per request.
- APU_WOP, 6, opcode width.
- APU_NDSFLAGS, 15, downstream flag width.
- APU_NUSFLAGS, 5, upstream flag width.
- RESP_REG, 0, 1 = register the response path (+1 cycle latency).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- core_apu_req_i  in  NUM_CORES  request per core.
- core_apu_gnt_o  out  NUM_CORES  grant per core.
- core_apu_operands_i  in  NUM_CORES*APU_NARGS*32  operands, core-major.
- core_apu_op_i  in  NUM_CORES*APU_WOP  opcode per core.
- core_apu_flags_i  in  NUM_CORES*APU_NDSFLAGS  flags per core.
- core_apu_rvalid_o  out  NUM_CORES  result valid, one-hot or zero.
- core_apu_result_o  out  32  result, broadcast to all cores.
- core_apu_rflags_o  out  APU_NUSFLAGS  result flags, broadcast.
- fpu_req_o  out  1  request to FPU.
- fpu_gnt_i  in  1  FPU grant.
- fpu_operands_o  out  APU_NARGS*32  selected operands.
- fpu_op_o  out  APU_WOP  selected opcode.
- fpu_flags_o  out  APU_NDSFLAGS  selected flags.
- fpu_rvalid_i  in  1  FPU result valid; FPU returns results in issue order.
- fpu_result_i  in  32  FPU result.
- fpu_rflags_i  in  APU_NUSFLAGS  FPU result flags.
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  operations in flight.
- err_o  out  1  sticky protocol error.

Behaviour:
- Clocking and reset: all state is clocked on clk_i, and reset is synchronous active-low on rst_ni. Reset clears the rr pointer to 0, the lock, the FIFO (count 0, rd/wr pointers 0) and err_o to 0. Under reset every output is 0 (the RESP_REG stage is cleared).
- Core request rule: a core holds its req, operands, op and flags stable from req high until it sees gnt.
- Arbitration (combinational, unlocked case):
  - Winner is the first core with req=1, scanning from rr_ptr upward with wrap at NUM_CORES.
  - fpu_req_o = any core req and FIFO not full.
  - fpu_operands_o, fpu_op_o and fpu_flags_o come from the winner. When fpu_req_o=0 they are 0.
- Lock:
  - If fpu_req_o=1 and fpu_gnt_i=0, lock<=1 and locked_idx<=winner.
  - While locked, the winner is locked_idx regardless of other requests.
  - The lock clears on handshake.
- Full FIFO: fpu_req_o=0 and the lock is held, even if a pop happens in the same cycle (no pass-through when full).
- Handshake (fpu_req_o & fpu_gnt_i):
  - core_apu_gnt_o[winner]=1 in the same cycle; all other grants are 0.
  - Push the winner index into the FIFO.
  - rr_ptr <= (winner+1) mod NUM_CORES.
- Response:
  - On fpu_rvalid_i with FIFO non-empty: pop the head, drive core_apu_rvalid_o[head]=1, and drive result and rflags from the FPU.
  - RESP_REG=0: combinational, same cycle.
  - RESP_REG=1: rvalid, result and rflags are registered, one cycle later.
  - When no response is valid, result and rflags are 0.
- Simultaneous push and pop (FIFO not full): both happen and the count is unchanged. Pointers wrap modulo MAX_OUTSTANDING.
- fpu_rvalid_i with FIFO empty: no core rvalid, err_o<=1 (sticky until reset), count stays 0.
- outstanding_o equals the FIFO count: +1 on push, -1 on pop.
- NUM_CORES=1 degenerates to a pass-through plus the outstanding limit.
- Reset mid-operation: in-flight tags are discarded. Any later FPU rvalid for those operations sets err_o; integration must reset the FPU with the arbiter.

Test Plan:
- Single core, back-to-back: core 2 req, gnt_i=1 each cycle, FPU latency 3. Required: core_apu_gnt_o=4'b0100, outstanding_o reaches 3, rvalid=4'b0100 three cycles after each grant, result 0xDEADBEEF passed through.
- Round-robin fairness: all 4 cores req continuously, gnt_i=1. Required: grant order 0,1,2,3,0,1 and no core granted twice within 4 grants.
- Lock: cores 1 and 3 req with rr_ptr=2 and gnt_i=0 for 3 cycles, then core 3 drops req while core 1 keeps req. Required: fpu_op_o stays core 3's op and no grant during the 3 stall cycles; core 1 is granted once gnt_i=1 (the lock had not cleared by handshake). Mirrored case: core 1 drops and core 3 keeps req, then gnt_i=1 gives core 3 the grant.
- Full FIFO: MAX_OUTSTANDING=2, no rvalid. Required: after 2 grants fpu_req_o=0 and outstanding_o=2. When fpu_rvalid_i pulses, a third grant is issued the next cycle, not the same cycle.
- Push+pop same cycle at count 1: outstanding_o stays 1, routing stays in order (cores 0,2,1 issue → rvalid to 0,2,1).
- Error and RESP_REG: spurious fpu_rvalid_i at count 0 → err_o=1 held until rst_ni=0. With RESP_REG=1, rvalid is 1 cycle later than with RESP_REG=0.
